// File: rtl/day_month_counter.sv
// Calendar date counter: day-of-month, month and year (00-99) with
// day-rollover advance, per-field user editing and month-length clamping.
module day_month_counter #(
  parameter int unsigned INIT_DIA  = 0,
  parameter int unsigned INIT_MES  = 0,
  parameter int unsigned INIT_ANIO = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick_dia,
  input  logic       Modo_edit,
  input  logic [1:0] Campo,
  input  logic       Inc,
  input  logic       Dec,
  output logic [4:0] Ref_dia,
  output logic [3:0] Ref_mes,
  output logic [6:0] Ref_anio,
  output logic       Tick_mes,
  output logic       Tick_anio,
  output logic       Ocupado
);

  localparam int unsigned DIA_W  = 5;
  localparam int unsigned MES_W  = 4;
  localparam int unsigned ANIO_W = 7;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLAMP = 1'b1;

  localparam logic [MES_W-1:0]  MES_MAX  = MES_W'(11);
  localparam logic [ANIO_W-1:0] ANIO_MAX = ANIO_W'(99);

  logic [0:0]        state, state_nx;
  logic              pend, pend_nx;
  logic [DIA_W-1:0]  dia_nx;
  logic [MES_W-1:0]  mes_nx;
  logic [ANIO_W-1:0] anio_nx;
  logic              tick_mes_nx, tick_anio_nx;
  logic [DIA_W-1:0]  lim;
  logic              advance;
  logic              edit_ok;

  // Last valid day index of a month; February depends on the leap test.
  function automatic logic [DIA_W-1:0] last_day(input logic [MES_W-1:0] mes,
                                                input logic [ANIO_W-1:0] anio);
    case (mes)
      MES_W'(1):                         last_day = (anio[1:0] == 2'b00) ? DIA_W'(28) : DIA_W'(27);
      MES_W'(3), MES_W'(5), MES_W'(8), MES_W'(10): last_day = DIA_W'(29);
      default:                           last_day = DIA_W'(30);
    endcase
  endfunction

  assign lim     = last_day(Ref_mes, Ref_anio);
  assign advance = (Tick_dia && !Modo_edit) || pend;
  assign edit_ok = Modo_edit && (Inc ^ Dec) && (Campo != 2'd3);

  // Next-state, next-date and pulse decode.
  always_comb begin
    state_nx     = state;
    pend_nx      = pend;
    dia_nx       = Ref_dia;
    mes_nx       = Ref_mes;
    anio_nx      = Ref_anio;
    tick_mes_nx  = 1'b0;
    tick_anio_nx = 1'b0;
    if (state == IDLE) begin
      if (advance) begin
        // A pending tick and a fresh tick merge into a single advance.
        pend_nx = 1'b0;
        if (Ref_dia < lim) begin
          dia_nx = Ref_dia + DIA_W'(1);
        end else begin
          dia_nx      = '0;
          tick_mes_nx = 1'b1;
          if (Ref_mes == MES_MAX) begin
            mes_nx       = '0;
            tick_anio_nx = 1'b1;
            anio_nx      = (Ref_anio >= ANIO_MAX) ? '0 : Ref_anio + ANIO_W'(1);
          end else if (Ref_mes > MES_MAX) begin
            mes_nx = '0;
          end else begin
            mes_nx = Ref_mes + MES_W'(1);
          end
        end
      end else if (edit_ok) begin
        case (Campo)
          2'd0: begin
            if (Ref_dia > lim)     dia_nx = '0;
            else if (Inc)          dia_nx = (Ref_dia == lim) ? '0 : Ref_dia + DIA_W'(1);
            else                   dia_nx = (Ref_dia == '0) ? lim : Ref_dia - DIA_W'(1);
          end
          2'd1: begin
            if (Ref_mes > MES_MAX) mes_nx = '0;
            else if (Inc)          mes_nx = (Ref_mes == MES_MAX) ? '0 : Ref_mes + MES_W'(1);
            else                   mes_nx = (Ref_mes == '0) ? MES_MAX : Ref_mes - MES_W'(1);
            state_nx = CLAMP;
          end
          2'd2: begin
            if (Ref_anio > ANIO_MAX) anio_nx = '0;
            else if (Inc)            anio_nx = (Ref_anio == ANIO_MAX) ? '0 : Ref_anio + ANIO_W'(1);
            else                     anio_nx = (Ref_anio == '0) ? ANIO_MAX : Ref_anio - ANIO_W'(1);
            state_nx = CLAMP;
          end
          default: ;
        endcase
      end
    end else begin
      // Pull the day back inside the (possibly shorter) new month.
      if (Ref_dia > lim) dia_nx = lim;
      if (Tick_dia && !Modo_edit) pend_nx = 1'b1;
      state_nx = IDLE;
    end
  end

  // State, date and pulse registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      pend      <= 1'b0;
      Ref_dia   <= DIA_W'(INIT_DIA);
      Ref_mes   <= MES_W'(INIT_MES);
      Ref_anio  <= ANIO_W'(INIT_ANIO);
      Tick_mes  <= 1'b0;
      Tick_anio <= 1'b0;
      Ocupado   <= 1'b0;
    end else begin
      state     <= state_nx;
      pend      <= pend_nx;
      Ref_dia   <= dia_nx;
      Ref_mes   <= mes_nx;
      Ref_anio  <= anio_nx;
      Tick_mes  <= tick_mes_nx;
      Tick_anio <= tick_anio_nx;
      Ocupado   <= (state_nx != IDLE);
    end
  end

endmodule
